// File: rtl/collision_event_unit.sv
// collision_event_unit: per-frame snapshot and serial segment scan producing edge-qualified event pulses,
// plus the player lives / invulnerability / game-over state. Optional macro SHEEP_PICKUP_EN adds sheep pickups.
`default_nettype none

module collision_event_unit #(
  parameter int NUM_SEGMENTS = 7,
  parameter int POS_W        = 8,
  parameter int LIVES_W      = 2,
  parameter int START_LIVES  = 3,
  parameter int IFRAMES      = 60,
  parameter int IDX_W        = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_end_i,
  input  logic                          restart_i,
  input  logic [POS_W-1:0]              player_pos_i,
  input  logic [POS_W-1:0]              sword_pos_i,
  input  logic                          sword_active_i,
  input  logic [POS_W-1:0]              sheep_pos_i,
  input  logic [NUM_SEGMENTS*POS_W-1:0] seg_pos_i,
  input  logic [NUM_SEGMENTS-1:0]       seg_active_i,
  output logic                          player_hit_o,
  output logic                          sword_hit_o,
  output logic [IDX_W-1:0]              hit_idx_o,
  output logic                          sheep_eaten_o,
  output logic                          sheep_pickup_o,
  output logic                          contact_o,
  output logic [LIVES_W-1:0]            lives_o,
  output logic                          invulnerable_o,
  output logic                          game_over_o
);

  localparam int IFR_W = $clog2(IFRAMES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGMENTS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d, rec_idx_q, rec_idx_d, hit_idx_q, hit_idx_d;
  logic [POS_W-1:0]                snap_player_q, snap_player_d, snap_sword_q, snap_sword_d;
  logic [POS_W-1:0]                snap_sheep_q, snap_sheep_d;
  logic                            snap_swa_q, snap_swa_d;
  logic [NUM_SEGMENTS*POS_W-1:0]   snap_seg_q, snap_seg_d;
  logic [NUM_SEGMENTS-1:0]         snap_act_q, snap_act_d;
  logic                            p_q, p_d, sw_q, sw_d, sh_q, sh_d;
  logic                            prev_p_q, prev_p_d, prev_sw_q, prev_sw_d, prev_sh_q, prev_sh_d;
  logic                            player_hit_q, player_hit_d, sword_hit_q, sword_hit_d;
  logic                            sheep_eaten_q, sheep_eaten_d, pickup_q, pickup_d;
  logic                            contact_q, contact_d, inv_q, inv_d, go_q, go_d;
  logic [LIVES_W-1:0]              lives_q, lives_d;
  logic [IFR_W-1:0]                ifr_q, ifr_d;
  logic [POS_W-1:0]                seg_cur;
  logic                            act_cur, hit, pk;
`ifdef SHEEP_PICKUP_EN
  localparam logic [LIVES_W-1:0] LIVES_MAX = '1;
  logic                            prev_pk_q, prev_pk_d;
`endif

  assign seg_cur = snap_seg_q[idx_q*POS_W +: POS_W];
  assign act_cur = snap_act_q[idx_q];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rec_idx_d     = rec_idx_q;
    hit_idx_d     = hit_idx_q;
    snap_player_d = snap_player_q;
    snap_sword_d  = snap_sword_q;
    snap_sheep_d  = snap_sheep_q;
    snap_swa_d    = snap_swa_q;
    snap_seg_d    = snap_seg_q;
    snap_act_d    = snap_act_q;
    p_d           = p_q;
    sw_d          = sw_q;
    sh_d          = sh_q;
    prev_p_d      = prev_p_q;
    prev_sw_d     = prev_sw_q;
    prev_sh_d     = prev_sh_q;
    contact_d     = contact_q;
    lives_d       = lives_q;
    inv_d         = inv_q;
    ifr_d         = ifr_q;
    go_d          = go_q;
    player_hit_d  = 1'b0;
    sword_hit_d   = 1'b0;
    sheep_eaten_d = 1'b0;
    pickup_d      = 1'b0;
    hit           = 1'b0;
    pk            = 1'b0;
`ifdef SHEEP_PICKUP_EN
    prev_pk_d     = prev_pk_q;
`endif

    // The iframe window counts frames, not scans, so every frame_end ticks it.
    if (frame_end_i && inv_q) begin
      ifr_d = ifr_q - 1'b1;
      if (ifr_q == IFR_W'(1)) inv_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_end_i && !go_q) begin
          snap_player_d = player_pos_i;
          snap_sword_d  = sword_pos_i;
          snap_swa_d    = sword_active_i;
          snap_sheep_d  = sheep_pos_i;
          snap_seg_d    = seg_pos_i;
          snap_act_d    = seg_active_i;
          idx_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (act_cur) begin
          if (snap_player_q == seg_cur) p_d = 1'b1;
          if (snap_swa_q && snap_sword_q == seg_cur && !sw_q) begin
            sw_d      = 1'b1;
            rec_idx_d = idx_q;
          end
          if (idx_q == '0 && snap_sheep_q == seg_cur) sh_d = 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = RESOLVE;
        else                   idx_d   = idx_q + 1'b1;
      end
      RESOLVE: begin
        hit           = p_q & ~prev_p_q & ~inv_q & (lives_q != '0);
`ifdef SHEEP_PICKUP_EN
        pk            = (snap_player_q == snap_sheep_q) & ~prev_pk_q;
        prev_pk_d     = (snap_player_q == snap_sheep_q);
`endif
        contact_d     = p_q;
        sword_hit_d   = sw_q & ~prev_sw_q;
        hit_idx_d     = rec_idx_q;
        sheep_eaten_d = sh_q & ~prev_sh_q;
        player_hit_d  = hit;
        pickup_d      = pk;
        prev_p_d      = p_q;
        prev_sw_d     = sw_q;
        prev_sh_d     = sh_q;
        p_d           = 1'b0;
        sw_d          = 1'b0;
        sh_d          = 1'b0;
        rec_idx_d     = '0;
        state_d       = IDLE;
        // A pickup landing with a hit cancels the life loss but not the iframes.
        if (hit) begin
          inv_d = 1'b1;
          ifr_d = IFR_W'(IFRAMES);
          if (!pk) begin
            lives_d = lives_q - 1'b1;
            if (lives_q == LIVES_W'(1)) begin
              go_d  = 1'b1;
              inv_d = 1'b0;
              ifr_d = '0;
            end
          end
`ifdef SHEEP_PICKUP_EN
        end else if (pk && lives_q != LIVES_MAX) begin
          lives_d = lives_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart_i) begin
      state_d       = IDLE;
      idx_d         = '0;
      rec_idx_d     = '0;
      hit_idx_d     = '0;
      snap_player_d = '0;
      snap_sword_d  = '0;
      snap_sheep_d  = '0;
      snap_swa_d    = 1'b0;
      snap_seg_d    = '0;
      snap_act_d    = '0;
      {p_d, sw_d, sh_d, prev_p_d, prev_sw_d, prev_sh_d} = '0;
      {player_hit_d, sword_hit_d, sheep_eaten_d, pickup_d} = '0;
      contact_d     = 1'b0;
      lives_d       = LIVES_W'(START_LIVES);
      inv_d         = 1'b0;
      ifr_d         = '0;
      go_d          = 1'b0;
`ifdef SHEEP_PICKUP_EN
      prev_pk_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      rec_idx_q     <= '0;
      hit_idx_q     <= '0;
      snap_player_q <= '0;
      snap_sword_q  <= '0;
      snap_sheep_q  <= '0;
      snap_swa_q    <= 1'b0;
      snap_seg_q    <= '0;
      snap_act_q    <= '0;
      {p_q, sw_q, sh_q, prev_p_q, prev_sw_q, prev_sh_q} <= '0;
      {player_hit_q, sword_hit_q, sheep_eaten_q, pickup_q} <= '0;
      contact_q     <= 1'b0;
      lives_q       <= LIVES_W'(START_LIVES);
      inv_q         <= 1'b0;
      ifr_q         <= '0;
      go_q          <= 1'b0;
`ifdef SHEEP_PICKUP_EN
      prev_pk_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rec_idx_q     <= rec_idx_d;
      hit_idx_q     <= hit_idx_d;
      snap_player_q <= snap_player_d;
      snap_sword_q  <= snap_sword_d;
      snap_sheep_q  <= snap_sheep_d;
      snap_swa_q    <= snap_swa_d;
      snap_seg_q    <= snap_seg_d;
      snap_act_q    <= snap_act_d;
      {p_q, sw_q, sh_q, prev_p_q, prev_sw_q, prev_sh_q} <= {p_d, sw_d, sh_d, prev_p_d, prev_sw_d, prev_sh_d};
      {player_hit_q, sword_hit_q, sheep_eaten_q, pickup_q} <= {player_hit_d, sword_hit_d, sheep_eaten_d, pickup_d};
      contact_q     <= contact_d;
      lives_q       <= lives_d;
      inv_q         <= inv_d;
      ifr_q         <= ifr_d;
      go_q          <= go_d;
`ifdef SHEEP_PICKUP_EN
      prev_pk_q     <= prev_pk_d;
`endif
    end
  end

  assign player_hit_o   = player_hit_q;
  assign sword_hit_o    = sword_hit_q;
  assign hit_idx_o      = hit_idx_q;
  assign sheep_eaten_o  = sheep_eaten_q;
  assign sheep_pickup_o = pickup_q;
  assign contact_o      = contact_q;
  assign lives_o        = lives_q;
  assign invulnerable_o = inv_q;
  assign game_over_o    = go_q;

endmodule

`default_nettype wire

// File: tb/tb_collision_event_unit.sv
// tb_collision_event_unit: random and directed frames checked by a queue scoreboard against a frame-level model.
`default_nettype none
`timescale 1ns/1ps

module tb_collision_event_unit;
  localparam int NS = 7;
  localparam int IFR = 60;

  logic            clk = 1'b0, rst_n = 1'b0, frame_end = 1'b0, restart = 1'b0;
  logic [7:0]      player_pos = '0, sword_pos = '0, sheep_pos = '0;
  logic            sword_active = 1'b0;
  logic [NS*8-1:0] seg_pos = '0;
  logic [NS-1:0]   seg_active = '0;
  logic            player_hit, sword_hit, sheep_eaten, sheep_pickup, contact, invulnerable, game_over;
  logic [2:0]      hit_idx;
  logic [1:0]      lives;

  collision_event_unit dut (
    .clk(clk), .rst_n(rst_n), .frame_end_i(frame_end), .restart_i(restart),
    .player_pos_i(player_pos), .sword_pos_i(sword_pos), .sword_active_i(sword_active),
    .sheep_pos_i(sheep_pos), .seg_pos_i(seg_pos), .seg_active_i(seg_active),
    .player_hit_o(player_hit), .sword_hit_o(sword_hit), .hit_idx_o(hit_idx),
    .sheep_eaten_o(sheep_eaten), .sheep_pickup_o(sheep_pickup), .contact_o(contact),
    .lives_o(lives), .invulnerable_o(invulnerable), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp; logic ph; logic sw; logic [2:0] idx; logic se; logic pk; logic ct;
    logic [1:0] lives; logic inv; logic go;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;
  int   cyc = 0, errors = 0, checks = 0;

  // Frame-level game model
  int m_lives, m_ifr;
  bit m_inv, m_go, m_ct, m_pp, m_psw, m_psh, m_ppk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_lives = 3; m_ifr = 0; m_inv = 0; m_go = 0; m_ct = 0;
    m_pp = 0; m_psw = 0; m_psh = 0; m_ppk = 0;
  endfunction

  function automatic void tick_iframe();
    if (m_inv) begin
      m_ifr--;
      if (m_ifr == 0) m_inv = 0;
    end
  endfunction

  function automatic exp_t idle_exp(input int stamp);
    exp_t e;
    e.stamp = stamp; e.ph = 0; e.sw = 0; e.idx = 0; e.se = 0; e.pk = 0;
    e.ct = m_ct; e.lives = 2'(m_lives); e.inv = m_inv; e.go = m_go;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        me = exp_q.pop_front();
        checks++;
        if (me.stamp != cyc) begin
          errors++;
          $display("FAIL late_expect: stamp %0d unchecked, now cycle %0d", me.stamp, cyc);
        end else if ({player_hit, sword_hit, sheep_eaten, sheep_pickup, contact, lives, invulnerable, game_over} !==
                     {me.ph, me.sw, me.se, me.pk, me.ct, me.lives, me.inv, me.go} ||
                     (me.sw && hit_idx !== me.idx)) begin
          errors++;
          $display("FAIL frame_resp cyc=%0d got ph=%b sw=%b idx=%0d se=%b pk=%b ct=%b lives=%0d inv=%b go=%b want ph=%b sw=%b idx=%0d se=%b pk=%b ct=%b lives=%0d inv=%b go=%b",
                   cyc, player_hit, sword_hit, hit_idx, sheep_eaten, sheep_pickup, contact, lives, invulnerable, game_over,
                   me.ph, me.sw, me.idx, me.se, me.pk, me.ct, me.lives, me.inv, me.go);
        end
      end else begin
        checks++;
        if (player_hit || sword_hit || sheep_eaten || sheep_pickup) begin
          errors++;
          $display("FAIL stray_pulse cyc=%0d got ph=%b sw=%b se=%b pk=%b want all 0",
                   cyc, player_hit, sword_hit, sheep_eaten, sheep_pickup);
        end
      end
    end
  end

  task automatic do_frame(input logic [7:0] pl, input logic [7:0] sw, input logic swa, input logic [7:0] sh,
                          input logic [NS*8-1:0] segs, input logic [NS-1:0] act, input bit extra);
    exp_t e;
    bit p, h, k, ph, pk;
    int first;
    player_pos = pl; sword_pos = sw; sword_active = swa; sheep_pos = sh;
    seg_pos = segs; seg_active = act; frame_end = 1'b1;
    tick_iframe();
    if (extra) tick_iframe();
    e = idle_exp(cyc + NS + 2);
    if (!m_go) begin
      p = 0; first = -1;
      for (int i = 0; i < NS; i++) begin
        if (act[i] && segs[i*8 +: 8] == pl) p = 1;
        if (act[i] && swa && segs[i*8 +: 8] == sw && first < 0) first = i;
      end
      h  = act[0] && segs[7:0] == sh;
      k  = (pl == sh);
      ph = p && !m_pp && !m_inv;
      pk = 0;
`ifdef SHEEP_PICKUP_EN
      pk = k && !m_ppk;
      m_ppk = k;
`endif
      e.ph = ph; e.pk = pk;
      e.sw = (first >= 0) && !m_psw;
      e.idx = (first >= 0) ? 3'(first) : 3'd0;
      e.se = h && !m_psh;
      m_ct = p; m_pp = p; m_psw = (first >= 0); m_psh = h;
      if (ph && pk) begin
        m_inv = 1; m_ifr = IFR;
      end else if (ph) begin
        m_lives--;
        if (m_lives == 0) begin m_go = 1; m_inv = 0; end
        else begin m_inv = 1; m_ifr = IFR; end
      end else if (pk && m_lives < 3) begin
        m_lives++;
      end
      e.ct = m_ct; e.lives = 2'(m_lives); e.inv = m_inv; e.go = m_go;
    end
    exp_q.push_back(e);
    @(posedge clk); #1; frame_end = 1'b0;
    @(posedge clk); #1;
    if (extra) frame_end = 1'b1;
    @(posedge clk); #1; frame_end = 1'b0;
    repeat (NS + 1) @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1; frame_end = 1'b1;
    model_reset();
    exp_q.push_back(idle_exp(cyc + 1));
    @(posedge clk); #1; restart = 1'b0; frame_end = 1'b0;
    repeat (NS + 3) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom % 4)
      0: return 8'h22;
      1: return 8'h55;
      2: return 8'h99;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NS*8-1:0] s, s2, rs;
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    exp_q.push_back(idle_exp(cyc));
    @(posedge clk); #1;

    // Reset asserted while a colliding frame is mid-scan.
    s = '0; s[3*8 +: 8] = 8'h55;
    player_pos = 8'h55; seg_pos = s; seg_active = '1; sheep_pos = 8'h99; frame_end = 1'b1;
    @(posedge clk); #1; frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #3; rst_n = 1'b1;
    exp_q.push_back(idle_exp(cyc));
    repeat (NS + 4) @(posedge clk);
    #1;

    // Player hit then 69 more frames of sustained overlap.
    for (int f = 0; f < 70; f++) do_frame(8'h55, 8'h22, 1'b0, 8'h99, s, '1, 1'b0);
    do_frame(8'h11, 8'h22, 1'b0, 8'h99, s, '1, 1'b0);

    // Sword priority and gating.
    s2 = '0; s2[2*8 +: 8] = 8'h22; s2[5*8 +: 8] = 8'h22;
    do_frame(8'h11, 8'h22, 1'b1, 8'h99, s2, '1, 1'b0);
    do_frame(8'h11, 8'h22, 1'b0, 8'h99, s2, '1, 1'b0);
    do_frame(8'h11, 8'h22, 1'b1, 8'h99, s2, 7'h7B, 1'b0);
    do_frame(8'h11, 8'h22, 1'b0, 8'h99, s2, '1, 1'b0);
    do_frame(8'h11, 8'h22, 1'b0, 8'h99, s2, '1, 1'b0);
    do_frame(8'h11, 8'h22, 1'b1, 8'h99, s2, '0, 1'b0);

    // Head eats sheep.
    do_frame(8'h11, 8'h22, 1'b0, 8'h00, s2, '1, 1'b0);

    // Drive to game over with separated hits, then frames are ignored, then restart with frame_end.
    do_frame(8'h55, 8'h22, 1'b0, 8'h99, s, '1, 1'b0);
    for (int f = 0; f < 31; f++) do_frame(8'h11, 8'h22, 1'b0, 8'h99, s, '1, 1'b1);
    do_frame(8'h55, 8'h22, 1'b0, 8'h99, s, '1, 1'b0);
    for (int f = 0; f < 3; f++) do_frame(8'h55, 8'h22, 1'b1, 8'h00, s2, '1, 1'b0);
    do_restart();
    do_frame(8'h55, 8'h22, 1'b0, 8'h99, s, '1, 1'b0);

    // Random frames from a small position pool so collisions are frequent.
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < NS; i++) rs[i*8 +: 8] = pick();
      if ((m_go && ($urandom % 2 == 0)) || ($urandom % 25 == 0)) do_restart();
      else do_frame(pick(), pick(), 1'($urandom), pick(), rs, NS'($urandom), ($urandom % 4) == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
